// File: rtl/conv3x3_tm_multich.sv
// Multi-channel, multi-filter 3x3 convolution engine built around one time-multiplexed MAC.
// Pixels stream through per-channel line buffers; weights and biases come from external synchronous ROMs.
module conv3x3_tm_multich #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned IN_CH       = 1,
  parameter int unsigned NUM_FILTERS = 32,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned RELU        = 0,
  parameter int unsigned WADDR_W     = 15,
  parameter int unsigned FADDR_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_CH*DATA_WIDTH-1:0] pixel_in,
  output logic [WADDR_W-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]       w_data,
  output logic [FADDR_W-1:0]          b_addr,
  input  logic [DATA_WIDTH-1:0]       b_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       pixel_out,
  output logic [FADDR_W-1:0]          filter_out,
  output logic                        frame_done
);

  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned AW       = ACC_WIDTH;
  localparam int unsigned N_TAPS   = IN_CH * 9;
  localparam int unsigned CNT_W    = $clog2(N_TAPS + 1);
  localparam int unsigned LB_DEPTH = 2 * IMG_WIDTH + 2;
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH + 1);
  localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT + 1);

  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_EMIT} state_t;

  state_t                 state_q, state_d;
  logic [COL_W-1:0]       col_q;
  logic [ROW_W-1:0]       row_q;
  logic [FADDR_W-1:0]     f_q, f_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   last_win_q, last_win_d;

  logic                   in_ready_d, out_valid_d, frame_done_d;
  logic [DW-1:0]          pixel_out_d;
  logic [FADDR_W-1:0]     filter_out_d, b_addr_d;
  logic [WADDR_W-1:0]     w_addr_d;

  logic                   xfer_c, win_c, rot_c;
  logic [DW-1:0]          lb     [IN_CH][LB_DEPTH];
  logic [DW-1:0]          line_c [IN_CH][LB_DEPTH+1];
  logic signed [DW-1:0]   patch  [N_TAPS];
  logic signed [2*DW-1:0] prod_c;
  logic signed [AW-1:0]   sum_c, shift_c;
  logic [DW-1:0]          requant_c;

  assign xfer_c = in_valid && in_ready;
  assign win_c  = xfer_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Raster position of the next incoming beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (xfer_c) begin
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Element k of line_c is the beat k transfers before the current one (k=0 is the current beat)
  always_comb begin
    for (int c = 0; c < int'(IN_CH); c++) begin
      line_c[c][0] = pixel_in[c*DW +: DW];
      for (int k = 0; k < int'(LB_DEPTH); k++) line_c[c][k+1] = lb[c][k];
    end
  end

  // Line buffers and window patch hold data only, so they carry no reset.
  // The patch rotates one tap per MAC step and is back in order after each filter.
  always_ff @(posedge clk) begin
    if (xfer_c) begin
      for (int c = 0; c < int'(IN_CH); c++) begin
        lb[c][0] <= pixel_in[c*DW +: DW];
        for (int k = 1; k < int'(LB_DEPTH); k++) lb[c][k] <= lb[c][k-1];
      end
    end
    if (win_c) begin
      for (int c = 0; c < int'(IN_CH); c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            patch[c*9 + i*3 + j] <= line_c[c][(2 - i) * int'(IMG_WIDTH) + (2 - j)];
    end else if (rot_c) begin
      for (int k = 0; k < int'(N_TAPS) - 1; k++) patch[k] <= patch[k+1];
      patch[N_TAPS-1] <= patch[0];
    end
  end

  assign prod_c = patch[0] * $signed(w_data);

  // Bias add, arithmetic shift, saturation and optional ReLU
  always_comb begin
    sum_c   = acc_q + {{(AW - DW){b_data[DW-1]}}, b_data};
    shift_c = sum_c >>> SHIFT;
    if (RELU != 0 && shift_c < 0)  requant_c = '0;
    else if (shift_c > SAT_MAX)    requant_c = SAT_MAX[DW-1:0];
    else if (shift_c < SAT_MIN)    requant_c = SAT_MIN[DW-1:0];
    else                           requant_c = shift_c[DW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    f_d          = f_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    last_win_d   = last_win_q;
    in_ready_d   = in_ready;
    out_valid_d  = out_valid;
    pixel_out_d  = pixel_out;
    filter_out_d = filter_out;
    frame_done_d = 1'b0;
    w_addr_d     = w_addr;
    b_addr_d     = b_addr;
    rot_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_c) begin
          state_d    = S_MAC;
          in_ready_d = 1'b0;
          f_d        = '0;
          cnt_d      = '0;
          w_addr_d   = '0;
          b_addr_d   = '0;
          last_win_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) && (col_q == COL_W'(IMG_WIDTH - 1));
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + 1'b1;
        // Weight data lags its address by one cycle, so step 0 only clears
        if (cnt_q == '0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + {{(AW - 2*DW){prod_c[2*DW-1]}}, prod_c};
          rot_c = 1'b1;
        end
        if (cnt_q < CNT_W'(N_TAPS - 1)) w_addr_d = w_addr + 1'b1;
        if (cnt_q == CNT_W'(N_TAPS)) state_d = S_BIAS;
      end
      S_BIAS: begin
        state_d      = S_EMIT;
        out_valid_d  = 1'b1;
        pixel_out_d  = requant_c;
        filter_out_d = f_q;
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (f_q < FADDR_W'(NUM_FILTERS - 1)) begin
            state_d  = S_MAC;
            f_d      = f_q + 1'b1;
            cnt_d    = '0;
            w_addr_d = w_addr + 1'b1;  // last tap of f is followed by tap 0 of f+1
            b_addr_d = f_q + 1'b1;
          end else begin
            state_d      = S_IDLE;
            in_ready_d   = 1'b1;
            frame_done_d = last_win_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      f_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      last_win_q <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      filter_out <= '0;
      frame_done <= 1'b0;
      w_addr     <= '0;
      b_addr     <= '0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      last_win_q <= last_win_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      pixel_out  <= pixel_out_d;
      filter_out <= filter_out_d;
      frame_done <= frame_done_d;
      w_addr     <= w_addr_d;
      b_addr     <= b_addr_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_tm_multich.sv
// Directed bench for conv3x3_tm_multich: a 5x5 two-channel two-filter engine and
// a 4x4 single-channel engine with SHIFT=2 and ReLU, each fed from bench-side ROMs.
module tb_conv3x3_tm_multich;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [15:0] pixel_in;
  logic [14:0] w_addr;
  logic [4:0]  b_addr, filter_out;
  logic [7:0]  w_data, b_data, pixel_out;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
  logic [7:0]  pixel_in2;
  logic [14:0] w_addr2;
  logic [4:0]  b_addr2, filter_out2;
  logic [7:0]  w_data2, b_data2, pixel_out2;

  logic [7:0]  wrom [64];
  logic [7:0]  brom [2];
  logic [7:0]  wrom2 [32];
  logic [7:0]  brom2 [2];

  int q_val[$], q_f[$], q2_val[$], q2_f[$];
  int fd_cnt, fd2_cnt, n_xfer;
  int n_cmp, n_fail;

  typedef struct {
    int pix; int w; int b0; int b1; int e0; int e1;
  } vec_t;
  vec_t vecs[7];

  conv3x3_tm_multich #(
    .DATA_WIDTH(8), .ACC_WIDTH(24), .IMG_WIDTH(5), .IMG_HEIGHT(5), .IN_CH(2),
    .NUM_FILTERS(2), .SHIFT(0), .RELU(0), .WADDR_W(15), .FADDR_W(5)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr),
    .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready),
    .pixel_out(pixel_out), .filter_out(filter_out), .frame_done(frame_done)
  );

  conv3x3_tm_multich #(
    .DATA_WIDTH(8), .ACC_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(4), .IN_CH(1),
    .NUM_FILTERS(2), .SHIFT(2), .RELU(1), .WADDR_W(15), .FADDR_W(5)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .pixel_in(pixel_in2), .w_addr(w_addr2), .w_data(w_data2), .b_addr(b_addr2),
    .b_data(b_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .pixel_out(pixel_out2), .filter_out(filter_out2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data for an address appears after the next rising edge
  always @(posedge clk) begin
    w_data  <= wrom[w_addr[5:0]];
    b_data  <= brom[b_addr[0]];
    w_data2 <= wrom2[w_addr2[4:0]];
    b_data2 <= brom2[b_addr2[0]];
  end

  // Observe handshakes on the falling edge, ahead of the edge that completes them
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_val.push_back(int'($signed(pixel_out)));
      q_f.push_back(int'(filter_out));
    end
    if (out_valid2 && out_ready2) begin
      q2_val.push_back(int'($signed(pixel_out2)));
      q2_f.push_back(int'(filter_out2));
    end
    if (frame_done)  fd_cnt++;
    if (frame_done2) fd2_cnt++;
    if (in_valid && in_ready) n_xfer++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beat(input bit sel, input logic [15:0] data);
    int t;
    t = 0;
    if (sel) begin pixel_in2 = data[7:0]; in_valid2 = 1'b1; end
    else     begin pixel_in  = data;      in_valid  = 1'b1; end
    forever begin
      @(negedge clk);
      if ((sel ? in_ready2 : in_ready) == 1'b1) break;
      t++;
      if (t > 2000) begin
        check("beat_timeout", t, 0);
        break;
      end
    end
    @(posedge clk); #1;
    if (sel) in_valid2 = 1'b0;
    else     in_valid  = 1'b0;
  endtask

  task automatic wait_outputs(input bit sel, input int n);
    int t;
    t = 0;
    while (((sel ? q2_val.size() : q_val.size()) < n) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    q_val.delete(); q_f.delete(); q2_val.delete(); q2_f.delete();
    fd_cnt = 0; fd2_cnt = 0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready",   int'(in_ready),   1);
    check("rst_out_valid",  int'(out_valid),  0);
    check("rst_pixel_out",  int'(pixel_out),  0);
    check("rst_filter_out", int'(filter_out), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_w_addr",     int'(w_addr),     0);
    check("rst_b_addr",     int'(b_addr),     0);
  endtask

  // Varied test pattern for the golden-model frame
  function automatic int px(int c, int r, int col);
    return ((r * 5 + col) * 3 + c * 7) % 11 - 5;
  endfunction

  function automatic int wv(int a);
    return (a * 5) % 7 - 3;
  endfunction

  function automatic int model(int r, int col, int f, int bias);
    int s;
    s = bias;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          s += px(c, r - 2 + i, col - 2 + j) * wv(f * 18 + c * 9 + i * 3 + j);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic load_varied();
    for (int a = 0; a < 64; a++) wrom[a] = 8'(wv(a));
    brom[0] = 8'(5);
    brom[1] = 8'(-3);
  endtask

  task automatic send_varied(input int n_beats);
    for (int b = 0; b < n_beats; b++)
      send_beat(1'b0, {8'(px(1, b / 5, b % 5)), 8'(px(0, b / 5, b % 5))});
  endtask

  task automatic check_varied(input int n);
    int k;
    k = 0;
    for (int r = 2; r < 5; r++)
      for (int col = 2; col < 5; col++)
        for (int f = 0; f < 2; f++) begin
          if (k < n && k < q_val.size()) begin
            check($sformatf("gold_val[%0d]", k), q_val[k], model(r, col, f, f == 0 ? 5 : -3));
            check($sformatf("gold_f[%0d]", k), q_f[k], f);
          end
          k++;
        end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_xfer = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; pixel_in2 = '0; out_ready2 = 1'b1;
    clear_obs();
    for (int a = 0; a < 64; a++) wrom[a] = '0;
    for (int a = 0; a < 32; a++) wrom2[a] = '0;
    brom[0] = '0; brom[1] = '0; brom2[0] = '0; brom2[1] = '0;

    vecs[0] = '{pix: 1,   w: 1,    b0: 0,   b1: 0,   e0: 18,   e1: 18};
    vecs[1] = '{pix: 1,   w: 1,    b0: 5,   b1: -3,  e0: 23,   e1: 15};
    vecs[2] = '{pix: 127, w: 127,  b0: 0,   b1: 0,   e0: 127,  e1: 127};
    vecs[3] = '{pix: 127, w: -127, b0: 0,   b1: 0,   e0: -128, e1: -128};
    vecs[4] = '{pix: -2,  w: 3,    b0: 10,  b1: -10, e0: -98,  e1: -118};
    vecs[5] = '{pix: 2,   w: -3,   b0: 127, b1: 0,   e0: 19,   e1: -108};
    vecs[6] = '{pix: 0,   w: 5,    b0: -7,  b1: 100, e0: -7,   e1: 100};

    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uniform full frames: 9 windows x 2 filters, alternating filter index
    for (int v = 0; v < 7; v++) begin
      for (int a = 0; a < 64; a++) wrom[a] = 8'(vecs[v].w);
      brom[0] = 8'(vecs[v].b0);
      brom[1] = 8'(vecs[v].b1);
      clear_obs();
      for (int b = 0; b < 25; b++) send_beat(1'b0, {8'(vecs[v].pix), 8'(vecs[v].pix)});
      wait_outputs(1'b0, 18);
      check($sformatf("v%0d_count", v), q_val.size(), 18);
      for (int i = 0; i < 18; i++)
        if (i < q_val.size()) begin
          check($sformatf("v%0d_val[%0d]", v, i), q_val[i], (i % 2 == 0) ? vecs[v].e0 : vecs[v].e1);
          check($sformatf("v%0d_f[%0d]", v, i), q_f[i], i % 2);
        end
      check($sformatf("v%0d_frame_done", v), fd_cnt, 1);
    end

    // Downstream stall in EMIT: outputs hold and no input beat is taken
    for (int a = 0; a < 64; a++) wrom[a] = 8'(1);
    brom[0] = '0; brom[1] = '0;
    clear_obs();
    out_ready = 1'b0;
    for (int b = 0; b < 13; b++) send_beat(1'b0, 16'h0101);
    pixel_in = 16'h0101;
    in_valid = 1'b1;
    begin
      int t;
      int x0;
      t = 0;
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      check("stall_out_valid_seen", int'(out_valid), 1);
      x0 = n_xfer;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("stall_out_valid",  int'(out_valid),            1);
        check("stall_pixel_out",  int'($signed(pixel_out)),  18);
        check("stall_filter_out", int'(filter_out),           0);
        check("stall_in_ready",   int'(in_ready),             0);
      end
      check("stall_no_xfer", n_xfer - x0, 0);
      check("stall_no_accept", q_val.size(), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int b = 13; b < 25; b++) send_beat(1'b0, 16'h0101);
    wait_outputs(1'b0, 18);
    check("stall_count", q_val.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < q_val.size()) begin
        check($sformatf("stall_val[%0d]", i), q_val[i], 18);
        check($sformatf("stall_f[%0d]", i), q_f[i], i % 2);
      end
    check("stall_frame_done", fd_cnt, 1);

    // Reset during MAC of the third window, then a full frame against the golden model
    load_varied();
    clear_obs();
    send_varied(15);
    check("pre_reset_count", q_val.size(), 4);
    check_varied(4);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    send_varied(25);
    wait_outputs(1'b0, 18);
    check("post_reset_count", q_val.size(), 18);
    check_varied(18);
    check("post_reset_frame_done", fd_cnt, 1);

    // SHIFT=2 with ReLU: filter 0 weights +1, filter 1 weights -1
    for (int a = 0; a < 32; a++) wrom2[a] = (a < 9) ? 8'(1) : 8'(-1);
    brom2[0] = '0; brom2[1] = '0;
    for (int s = 0; s < 2; s++) begin
      clear_obs();
      for (int b = 0; b < 16; b++) send_beat(1'b1, {8'd0, (s == 0) ? 8'(3) : 8'(-3)});
      wait_outputs(1'b1, 8);
      check($sformatf("sr%0d_count", s), q2_val.size(), 8);
      for (int i = 0; i < 8; i++)
        if (i < q2_val.size()) begin
          check($sformatf("sr%0d_val[%0d]", s, i), q2_val[i], ((i % 2) == s) ? 6 : 0);
          check($sformatf("sr%0d_f[%0d]", s, i), q2_f[i], i % 2);
        end
      check($sformatf("sr%0d_frame_done", s), fd2_cnt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
